// File: rtl/blake2_pkg.sv
// Shared sizes and FSM state type for the blake2 host-side message feeder.
package blake2_pkg;

    localparam int unsigned B2B_BLOCK_BYTES = 128;
    localparam int unsigned B2B_LL_W        = 128;
    localparam int unsigned B2B_NN_W        = 7;
    localparam int unsigned B2B_MAX_NN      = 64;
    localparam int unsigned B2B_F_GAP       = 106;

    localparam int unsigned B2S_BLOCK_BYTES = 64;
    localparam int unsigned B2S_LL_W        = 64;
    localparam int unsigned B2S_NN_W        = 6;
    localparam int unsigned B2S_MAX_NN      = 32;

    typedef enum logic [2:0] {
        StIdle,
        StKey,
        StKpad,
        StMsg,
        StPad,
        StGap,
        StRes,
        StDone
    } feed_state_e;

endpackage

// File: rtl/blake2_digest_collect.sv
// Gathers the core's streamed result bytes into a parallel digest register.
module blake2_digest_collect #(
    parameter int unsigned NN_W   = 7,
    parameter int unsigned MAX_NN = 64
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic [NN_W-1:0]       nn_i,
    input  logic                  finished_i,
    input  logic [7:0]            h_i,
    output logic [8*MAX_NN-1:0]   digest_o,
    output logic                  done_o
);

    logic                fin_q;
    logic [NN_W-1:0]     k_q, k_d;
    logic [8*MAX_NN-1:0] digest_q, digest_d;
    logic                store;

    // The result byte trails its finished cycle by one clock.
    assign store  = en_i & fin_q;
    assign done_o = store & (k_q == nn_i - NN_W'(1));

    always_comb begin
        k_d      = k_q;
        digest_d = digest_q;
        if (clear_i) begin
            k_d      = '0;
            digest_d = '0;
        end else if (store) begin
            k_d = k_q + NN_W'(1);
            for (int i = 0; i < MAX_NN; i++) begin
                if (k_q == NN_W'(i)) digest_d[8*i +: 8] = h_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            fin_q    <= 1'b0;
            k_q      <= '0;
            digest_q <= '0;
        end else begin
            fin_q    <= finished_i;
            k_q      <= k_d;
            digest_q <= digest_d;
        end
    end

    assign digest_o = digest_q;

endmodule

// File: rtl/blake2_msg_feeder.sv
// Feeds a key+message byte stream to the blake2 core as zero-padded blocks and
// collects the resulting digest.
module blake2_msg_feeder
    import blake2_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = B2B_BLOCK_BYTES,
    parameter int unsigned LL_W        = B2B_LL_W,
    parameter int unsigned NN_W        = B2B_NN_W,
    parameter int unsigned MAX_NN      = B2B_MAX_NN,
    parameter int unsigned F_GAP       = B2B_F_GAP
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic                           start_i,
    input  logic [NN_W-1:0]                kk_i,
    input  logic [NN_W-1:0]                nn_i,
    input  logic                           in_v_i,
    output logic                           in_ready_o,
    input  logic [7:0]                     in_data_i,
    input  logic                           in_last_i,
    input  logic                           in_empty_i,
    output logic [NN_W-1:0]                core_kk_o,
    output logic [NN_W-1:0]                core_nn_o,
    output logic [LL_W-1:0]                core_ll_o,
    output logic                           core_block_first_o,
    output logic                           core_block_last_o,
    output logic                           core_data_v_o,
    output logic [$clog2(BLOCK_BYTES)-1:0] core_data_idx_o,
    output logic [7:0]                     core_data_o,
    input  logic                           core_finished_i,
    input  logic [7:0]                     core_h_i,
    output logic [8*MAX_NN-1:0]            digest_o,
    output logic                           digest_v_o,
    output logic                           busy_o
);

    localparam int unsigned IDX_W = $clog2(BLOCK_BYTES);
    localparam int unsigned GAP_W = $clog2(F_GAP + 1);

    feed_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, oidx_q, oidx_d;
    logic [NN_W-1:0]  kk_q, kk_d, nn_q, nn_d, key_cnt_q, key_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [LL_W-1:0]  ll_q, ll_d;
    logic             first_q, first_d, last_q, last_d;
    logic             dv_q, dv_d, ofirst_q, ofirst_d, olast_q, olast_d;
    logic [7:0]       odata_q, odata_d;
    logic             xfer, blk_end, beat, beat_last, count_ll, collect_done;
    logic [7:0]       beat_byte;

    assign in_ready_o = (state_q == StKey) || (state_q == StMsg);
    assign xfer       = in_v_i & in_ready_o;
    assign blk_end    = idx_q == IDX_W'(BLOCK_BYTES - 1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        kk_d      = kk_q;
        nn_d      = nn_q;
        key_cnt_d = key_cnt_q;
        gap_d     = gap_q;
        ll_d      = ll_q;
        first_d   = first_q;
        last_d    = last_q;
        oidx_d    = oidx_q;
        odata_d   = odata_q;
        ofirst_d  = ofirst_q;
        olast_d   = olast_q;
        beat      = 1'b0;
        beat_byte = 8'h00;
        beat_last = last_q;
        count_ll  = 1'b0;
        case (state_q)
            StIdle: if (start_i) begin
                kk_d      = kk_i;
                nn_d      = nn_i;
                ll_d      = '0;
                idx_d     = '0;
                key_cnt_d = '0;
                gap_d     = '0;
                first_d   = 1'b1;
                last_d    = 1'b0;
                state_d   = (kk_i != '0) ? StKey : StMsg;
            end
            StKey: if (xfer) begin
                beat      = 1'b1;
                beat_byte = in_data_i;
                count_ll  = 1'b1;
                key_cnt_d = key_cnt_q + NN_W'(1);
                if (in_last_i) begin
                    last_d    = 1'b1;
                    beat_last = 1'b1;
                end
                if (key_cnt_q == kk_q - NN_W'(1)) state_d = blk_end ? StGap : StKpad;
            end
            // Key padding counts toward ll so the key block commits a full block.
            StKpad: begin
                beat     = 1'b1;
                count_ll = 1'b1;
                if (blk_end) state_d = StGap;
            end
            StMsg: if (xfer) begin
                if (in_last_i) begin
                    last_d    = 1'b1;
                    beat_last = 1'b1;
                end
                if (!(in_last_i && in_empty_i)) begin
                    beat      = 1'b1;
                    beat_byte = in_data_i;
                    count_ll  = 1'b1;
                end
                if (beat && blk_end) state_d = StGap;
                else if (in_last_i) state_d = StPad;
            end
            StPad: begin
                beat = 1'b1;
                if (blk_end) state_d = StGap;
            end
            StGap: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(F_GAP - 1)) begin
                    gap_d   = '0;
                    first_d = 1'b0;
                    state_d = last_q ? StRes : StMsg;
                end
            end
            StRes:   if (collect_done) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        dv_d = beat;
        if (beat) begin
            idx_d    = idx_q + IDX_W'(1);
            oidx_d   = idx_q;
            odata_d  = beat_byte;
            ofirst_d = first_q;
            olast_d  = beat_last;
        end
        if (count_ll) ll_d = ll_q + LL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            kk_q      <= '0;
            nn_q      <= '0;
            key_cnt_q <= '0;
            gap_q     <= '0;
            ll_q      <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            dv_q      <= 1'b0;
            oidx_q    <= '0;
            odata_q   <= 8'h00;
            ofirst_q  <= 1'b0;
            olast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            kk_q      <= kk_d;
            nn_q      <= nn_d;
            key_cnt_q <= key_cnt_d;
            gap_q     <= gap_d;
            ll_q      <= ll_d;
            first_q   <= first_d;
            last_q    <= last_d;
            dv_q      <= dv_d;
            oidx_q    <= oidx_d;
            odata_q   <= odata_d;
            ofirst_q  <= ofirst_d;
            olast_q   <= olast_d;
        end
    end

    blake2_digest_collect #(
        .NN_W   (NN_W),
        .MAX_NN (MAX_NN)
    ) u_collect (
        .clk        (clk),
        .nreset     (nreset),
        .clear_i    ((state_q == StIdle) && start_i),
        .en_i       (state_q == StRes),
        .nn_i       (nn_q),
        .finished_i (core_finished_i),
        .h_i        (core_h_i),
        .digest_o   (digest_o),
        .done_o     (collect_done)
    );

    assign core_kk_o          = kk_q;
    assign core_nn_o          = nn_q;
    assign core_ll_o          = ll_q;
    assign core_block_first_o = ofirst_q;
    assign core_block_last_o  = olast_q;
    assign core_data_v_o      = dv_q;
    assign core_data_idx_o    = oidx_q;
    assign core_data_o        = odata_q;
    assign digest_v_o         = state_q == StDone;
    assign busy_o             = state_q != StIdle;

endmodule

// File: tb/tb_blake2_msg_feeder.sv
// Randomized scoreboard bench for blake2_msg_feeder; the bench also plays the core's result phase.
module tb_blake2_msg_feeder;

    localparam int BB     = 128;
    localparam int LL_W   = 128;
    localparam int NN_W   = 7;
    localparam int MAX_NN = 64;
    localparam int F_GAP  = 106;

    logic                clk = 1'b0;
    logic                nreset = 1'b0;
    logic                start_i = 1'b0;
    logic [NN_W-1:0]     kk_i = '0, nn_i = '0;
    logic                in_v_i = 1'b0, in_last_i = 1'b0, in_empty_i = 1'b0;
    logic [7:0]          in_data_i = 8'h00;
    logic                in_ready_o;
    logic [NN_W-1:0]     core_kk_o, core_nn_o;
    logic [LL_W-1:0]     core_ll_o;
    logic                core_block_first_o, core_block_last_o, core_data_v_o;
    logic [6:0]          core_data_idx_o;
    logic [7:0]          core_data_o;
    logic                core_finished_i = 1'b0;
    logic [7:0]          core_h_i = 8'h00;
    logic [8*MAX_NN-1:0] digest_o;
    logic                digest_v_o, busy_o;

    always #5 clk = ~clk;

    blake2_msg_feeder dut (
        .clk                (clk),
        .nreset             (nreset),
        .start_i            (start_i),
        .kk_i               (kk_i),
        .nn_i               (nn_i),
        .in_v_i             (in_v_i),
        .in_ready_o         (in_ready_o),
        .in_data_i          (in_data_i),
        .in_last_i          (in_last_i),
        .in_empty_i         (in_empty_i),
        .core_kk_o          (core_kk_o),
        .core_nn_o          (core_nn_o),
        .core_ll_o          (core_ll_o),
        .core_block_first_o (core_block_first_o),
        .core_block_last_o  (core_block_last_o),
        .core_data_v_o      (core_data_v_o),
        .core_data_idx_o    (core_data_idx_o),
        .core_data_o        (core_data_o),
        .core_finished_i    (core_finished_i),
        .core_h_i           (core_h_i),
        .digest_o           (digest_o),
        .digest_v_o         (digest_v_o),
        .busy_o             (busy_o)
    );

    typedef struct {
        logic [6:0]      idx;
        logic [7:0]      data;
        logic            first;
        logic            last;
        logic [LL_W-1:0] ll;
    } beat_t;

    beat_t               exp_q[$];
    logic [8*MAX_NN-1:0] dig_q[$];
    logic [7:0]          stream_b[0:1023];
    int checks = 0, errors = 0;
    int beat_cnt = 0, res_req = 0, cur_nn = 1;

    task automatic check(input string name, input logic [8*MAX_NN-1:0] act,
                         input logic [8*MAX_NN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: key padded to one block, message padded to whole blocks (one block if all empty).
    task automatic push_expected(input int kk, input int len);
        int kb, nblk, last_from, m;
        beat_t e;
        kb        = (kk > 0) ? 1 : 0;
        nblk      = kb + ((len == 0) ? ((kk > 0) ? 0 : 1) : (len + BB - 1) / BB);
        last_from = (len > 0) ? kb * BB + len - 1 : ((kk > 0) ? kk - 1 : 0);
        for (int g = 0; g < nblk * BB; g++) begin
            e.idx   = 7'(g % BB);
            e.first = (g / BB) == 0;
            e.last  = g >= last_from;
            if (kb == 1 && g < BB) begin
                e.data = (g < kk) ? stream_b[g] : 8'h00;
                e.ll   = LL_W'(g + 1);
            end else begin
                m      = g - kb * BB;
                e.data = (m < len) ? stream_b[kk + m] : 8'h00;
                e.ll   = LL_W'(kb * BB + ((m + 1 < len) ? m + 1 : len));
            end
            exp_q.push_back(e);
        end
    endtask

    // Output monitor: beats and digests against the scoreboard queues.
    initial begin
        int    cyc, prev;
        beat_t e;
        cyc = 0;
        prev = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (nreset && core_data_v_o) begin
                beat_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got idx=%0d data=%02h, expected no beat",
                             core_data_idx_o, core_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (core_data_idx_o !== e.idx || core_data_o !== e.data ||
                        core_block_first_o !== e.first || core_block_last_o !== e.last ||
                        core_ll_o !== e.ll) begin
                        errors++;
                        $display("FAIL beat: got idx=%0d data=%02h first=%0b last=%0b ll=%0d, expected idx=%0d data=%02h first=%0b last=%0b ll=%0d",
                                 core_data_idx_o, core_data_o, core_block_first_o,
                                 core_block_last_o, core_ll_o, e.idx, e.data, e.first,
                                 e.last, e.ll);
                    end
                end
                if (core_data_idx_o == 7'd0 && !core_block_first_o) begin
                    checks++;
                    if (cyc - prev - 1 < F_GAP) begin
                        errors++;
                        $display("FAIL block_gap: got %0d idle cycles, expected >= %0d",
                                 cyc - prev - 1, F_GAP);
                    end
                end
                prev = cyc;
                if (core_data_idx_o == 7'(BB - 1) && core_block_last_o) res_req++;
            end
            if (nreset && digest_v_o) begin
                if (dig_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL digest_unexpected: got %0h, expected no digest", digest_o);
                end else begin
                    check("digest", digest_o, dig_q.pop_front());
                end
            end
        end
    end

    // Core result-phase model: finished strobes with random gaps, byte one cycle later.
    initial begin
        int                  served, sent, hi;
        bit                  pend;
        logic [7:0]          hb[0:MAX_NN-1];
        logic [8*MAX_NN-1:0] d;
        served = 0;
        forever begin
            wait (res_req != served);
            served++;
            d = '0;
            for (int k = 0; k < cur_nn; k++) begin
                hb[k]        = 8'($urandom);
                d[8*k +: 8] = hb[k];
            end
            dig_q.push_back(d);
            repeat (F_GAP + 3) @(negedge clk);
            sent = 0;
            hi   = 0;
            pend = 1'b0;
            while (sent < cur_nn || pend) begin
                @(negedge clk);
                if (pend) begin
                    core_h_i = hb[hi];
                    hi++;
                end else begin
                    core_h_i = 8'($urandom);
                end
                pend = 1'b0;
                if (sent < cur_nn && ($urandom % 4) != 0) begin
                    core_finished_i = 1'b1;
                    sent++;
                    pend = 1'b1;
                end else begin
                    core_finished_i = 1'b0;
                end
            end
            @(negedge clk);
            core_finished_i = 1'b0;
        end
    end

    // vmode: 0 always valid, 1 valid every other cycle, 2 random valid.
    task automatic drive_stream(input int n, input bit empty, input int vmode,
                                input int abort_after);
        int i, tmo;
        bit v, ph;
        i   = 0;
        tmo = 0;
        ph  = 1'b1;
        while (i < n && !(abort_after > 0 && i >= abort_after)) begin
            @(negedge clk);
            v          = (vmode == 0) ? 1'b1 : (vmode == 1) ? ph : (($urandom % 3) != 0);
            ph         = ~ph;
            in_v_i     = v;
            in_data_i  = empty ? 8'h00 : stream_b[i];
            in_last_i  = (i == n - 1);
            in_empty_i = empty;
            start_i    = ($urandom % 16) == 0;
            kk_i       = NN_W'($urandom);
            nn_i       = NN_W'($urandom);
            if (v && in_ready_o) begin
                i++;
            end else if (++tmo > 4000) begin
                checks++;
                errors++;
                $display("FAIL stream_stall: got %0d bytes accepted, expected %0d", i, n);
                break;
            end
        end
        @(negedge clk);
        in_v_i     = 1'b0;
        in_last_i  = 1'b0;
        in_empty_i = 1'b0;
        start_i    = 1'b0;
    endtask

    task automatic run_hash(input int kk, input int nn, input int len, input int vmode,
                            input int abort_after, input bit keep);
        int n, t, exp_n;
        bit empty;
        if (!keep) for (int i = 0; i < kk + len; i++) stream_b[i] = 8'($urandom);
        push_expected(kk, len);
        exp_n    = exp_q.size();
        cur_nn   = nn;
        beat_cnt = 0;
        @(negedge clk);
        start_i = 1'b1;
        kk_i    = NN_W'(kk);
        nn_i    = NN_W'(nn);
        n       = kk + len;
        empty   = (n == 0);
        if (empty) n = 1;
        drive_stream(n, empty, vmode, abort_after);
        if (abort_after > 0) return;
        t = 0;
        while (!digest_v_o && t < 6000) begin
            @(negedge clk);
            t++;
        end
        if (!digest_v_o) begin
            checks++;
            errors++;
            $display("FAIL digest_timeout: got no digest_v_o, expected one within 6000 cycles");
        end else begin
            @(negedge clk);
            check("digest_pulse_width", digest_v_o, 0);
            check("busy_after_digest", busy_o, 0);
            if (nn <= 32) check("digest_upper_zero", digest_o[511:256], 0);
        end
        check("core_kk", core_kk_o, kk);
        check("core_nn", core_nn_o, nn);
        check("beat_count", beat_cnt, exp_n);
        check("beats_left", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, in_ready_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_digest_v"}, digest_v_o, 0);
        check({tag, "_digest"}, digest_o, 0);
        check({tag, "_ll"}, core_ll_o, 0);
        check({tag, "_kk_nn"}, {core_kk_o, core_nn_o}, 0);
        check({tag, "_beat"}, {core_data_v_o, core_block_first_o, core_block_last_o,
                               core_data_idx_o, core_data_o}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of run, expected finish before 2 ms");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check_all_zero("reset");

        // Abort mid-message with a 3-cycle reset.
        run_hash(0, 64, 40, 0, 10, 0);
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("abort");
        nreset = 1'b1;
        exp_q.delete();
        @(negedge clk);

        stream_b[0] = 8'h61;
        stream_b[1] = 8'h62;
        stream_b[2] = 8'h63;
        run_hash(0, 64, 3, 0, 0, 1);
        run_hash(0, 64, 0, 0, 0, 0);
        run_hash(0, 64, 256, 0, 0, 0);
        run_hash(4, 64, 1, 0, 0, 0);
        run_hash(0, 32, 150, 1, 0, 0);
        run_hash(8, 16, 0, 2, 0, 0);
        for (int r = 0; r < 6; r++) begin
            int kk, nn, len;
            kk  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 64);
            nn  = $urandom_range(1, 64);
            len = $urandom_range(0, 300);
            run_hash(kk, nn, len, 2, 0, 0);
        end
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
